// File: rtl/gpio_cmd_pkg.sv
// Shared opcodes and field positions for the GPO/GPI command register file.
package gpio_cmd_pkg;

   localparam logic [7:0] OP_RESET       = 8'd0;
   localparam logic [7:0] OP_EN_TX       = 8'd1;
   localparam logic [7:0] OP_EN_RX       = 8'd2;
   localparam logic [7:0] OP_PH_SEL      = 8'd3;
   localparam logic [7:0] OP_RUN_MEM     = 8'd4;
   localparam logic [7:0] OP_READ_MEM    = 8'd5;
   localparam logic [7:0] OP_SNAP_BER    = 8'd6;
   localparam logic [7:0] OP_RD_BER      = 8'd7;
   localparam logic [7:0] OP_IS_MEM_FULL = 8'd8;
   localparam logic [7:0] OP_STATUS      = 8'd9;

   localparam int GPO_OP_MSB   = 31;
   localparam int GPO_OP_LSB   = 24;
   localparam int GPO_STB_BIT  = 23;
   localparam int GPO_DATA_MSB = 22;

   localparam int RDB_KIND_BIT = 0;
   localparam int RDB_WORD_LSB = 1;
   localparam int RDB_WORD_MSB = 4;
   localparam int RDB_CH_LSB   = 5;
   localparam int RDB_CH_MSB   = 12;

   localparam int ST_CMD_DROP    = 0;
   localparam int ST_ERR_UNKNOWN = 1;
   localparam int ST_ERR_RANGE   = 2;
   localparam int ST_BUSY        = 3;
   localparam int ST_MEM_FULL    = 4;

   function automatic logic is_known_op(input logic [7:0] op);
      return op <= OP_STATUS;
   endfunction

endpackage

// File: rtl/gpio_cmd_regfile_ber_snapshot_bank.sv
// Shadow copy of the BER sample/error counters with a 32-bit word read mux.
module ber_snapshot_bank #(
   parameter int N_CH   = 2,
   parameter int NB_CNT = 64
) (
   input  logic                     clk,
   input  logic                     i_rst,
   input  logic                     snap,
   input  logic [N_CH*NB_CNT-1:0]   samp,
   input  logic [N_CH*NB_CNT-1:0]   error,
   input  logic                     kind,
   input  logic [7:0]               ch,
   input  logic [3:0]               word,
   output logic [31:0]              rd_word,
   output logic                     range_err
);

   localparam int NW = NB_CNT / 32;

   logic [N_CH*NB_CNT-1:0] shadow_samp;
   logic [N_CH*NB_CNT-1:0] shadow_err;

   // all counters captured together on one edge so the snapshot is coherent
   always_ff @(posedge clk) begin
      if (i_rst) begin
         shadow_samp <= '0;
         shadow_err  <= '0;
      end else if (snap) begin
         shadow_samp <= samp;
         shadow_err  <= error;
      end
   end

   // select one 32-bit word; out-of-range selections read as zero
   always_comb begin
      range_err = (int'(ch) >= N_CH) || (int'(word) >= NW);
      rd_word   = '0;
      for (int c = 0; c < N_CH; c++) begin
         for (int w = 0; w < NW; w++) begin
            if (!range_err && int'(ch) == c && int'(word) == w) begin
               rd_word = kind ? shadow_err[c*NB_CNT + w*32 +: 32]
                              : shadow_samp[c*NB_CNT + w*32 +: 32];
            end
         end
      end
   end

endmodule

// File: rtl/gpio_cmd_regfile.sv
// GPO command decoder, control registers, log-memory read sequencer and
// sticky status for the processor-to-modem GPO/GPI bridge.
//
// state | meaning
// IDLE  | accepting commands
// WAIT  | log-memory read in flight, commands are dropped
module gpio_cmd_regfile
   import gpio_cmd_pkg::*;
#(
   parameter int NB_ADDR_MEM = 15,
   parameter int N_CH        = 2,
   parameter int NB_CNT      = 64,
   parameter int NB_PHASE    = 2,
   parameter int MEM_RD_LAT  = 2
) (
   input  logic                     clk,
   input  logic                     i_rst,
   input  logic [31:0]              i_gpo,
   input  logic [31:0]              i_data_log_from_mem,
   input  logic                     i_mem_full,
   input  logic [N_CH*NB_CNT-1:0]   i_ber_samp,
   input  logic [N_CH*NB_CNT-1:0]   i_ber_error,
   output logic [31:0]              o_gpi,
   output logic                     o_rst,
   output logic                     o_enbTx,
   output logic                     o_enbRx,
   output logic [NB_PHASE-1:0]      o_phase_sel,
   output logic                     o_run_log,
   output logic                     o_read_log,
   output logic [NB_ADDR_MEM-1:0]   o_addr_log_to_mem,
   output logic                     o_busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [7:0]  op;
   logic [22:0] data;
   logic        strb;
   logic        strb_prev;
   logic        fire;
   logic        accept;
   logic [0:0]  state;
   logic [2:0]  cnt;
   logic        err_range;
   logic        err_unknown;
   logic        cmd_drop;
   logic        snap;
   logic        st_clr;
   logic        drop_set;
   logic        unk_set;
   logic        rng_set;
   logic        rd_range_err;
   logic [31:0] rd_word;
   logic [31:0] status_word;

   assign op     = i_gpo[GPO_OP_MSB:GPO_OP_LSB];
   assign strb   = i_gpo[GPO_STB_BIT];
   assign data   = i_gpo[GPO_DATA_MSB:0];
   assign fire   = strb & ~strb_prev;
   assign o_busy = (state == ST_WAIT);
   assign accept = fire & ~o_busy;

   assign snap     = accept & (op == OP_SNAP_BER);
   assign st_clr   = accept & (op == OP_STATUS);
   assign drop_set = fire & o_busy;
   assign unk_set  = accept & ~is_known_op(op);
   assign rng_set  = accept & (op == OP_RD_BER) & rd_range_err;

   ber_snapshot_bank #(
      .N_CH   (N_CH),
      .NB_CNT (NB_CNT)
   ) u_snap (
      .clk       (clk),
      .i_rst     (i_rst),
      .snap      (snap),
      .samp      (i_ber_samp),
      .error     (i_ber_error),
      .kind      (data[RDB_KIND_BIT]),
      .ch        (data[RDB_CH_MSB:RDB_CH_LSB]),
      .word      (data[RDB_WORD_MSB:RDB_WORD_LSB]),
      .rd_word   (rd_word),
      .range_err (rd_range_err)
   );

   // status readback word assembled from the live sticky bits
   always_comb begin
      status_word                 = '0;
      status_word[ST_CMD_DROP]    = cmd_drop;
      status_word[ST_ERR_UNKNOWN] = err_unknown;
      status_word[ST_ERR_RANGE]   = err_range;
      status_word[ST_BUSY]        = o_busy;
      status_word[ST_MEM_FULL]    = i_mem_full;
   end

   // previous strobe, cleared in reset so a held strobe fires once after release
   always_ff @(posedge clk) begin
      if (i_rst) strb_prev <= 1'b0;
      else       strb_prev <= strb;
   end

   // control registers written by accepted commands
   always_ff @(posedge clk) begin
      if (i_rst) begin
         o_rst       <= 1'b0;
         o_enbTx     <= 1'b0;
         o_enbRx     <= 1'b0;
         o_phase_sel <= '0;
      end else if (accept) begin
         case (op)
            OP_RESET:  o_rst       <= data[0];
            OP_EN_TX:  o_enbTx     <= data[0];
            OP_EN_RX:  o_enbRx     <= data[0];
            OP_PH_SEL: o_phase_sel <= data[NB_PHASE-1:0];
            default:   ;
         endcase
      end
   end

   // strobes, read sequencer and the GPI readback register
   always_ff @(posedge clk) begin
      if (i_rst) begin
         o_run_log         <= 1'b0;
         o_read_log        <= 1'b0;
         o_addr_log_to_mem <= '0;
         o_gpi             <= '0;
         state             <= ST_IDLE;
         cnt               <= '0;
      end else begin
         o_run_log  <= 1'b0;
         o_read_log <= 1'b0;
         if (state == ST_WAIT) begin
            if (cnt == 3'd1) begin
               o_gpi <= i_data_log_from_mem;
               state <= ST_IDLE;
            end else begin
               cnt <= cnt - 3'd1;
            end
         end
         if (accept) begin
            case (op)
               OP_RUN_MEM: o_run_log <= 1'b1;
               OP_READ_MEM: begin
                  if (i_mem_full) begin
                     o_read_log        <= 1'b1;
                     o_addr_log_to_mem <= data[NB_ADDR_MEM-1:0];
                     state             <= ST_WAIT;
                     cnt               <= 3'(MEM_RD_LAT);
                  end else begin
                     o_gpi <= '0;
                  end
               end
               OP_RD_BER:      o_gpi <= rd_range_err ? 32'd0 : rd_word;
               OP_IS_MEM_FULL: o_gpi <= {31'd0, i_mem_full};
               OP_STATUS:      o_gpi <= status_word;
               default:        ;
            endcase
         end
      end
   end

   // sticky error flags; a STATUS read clears them but same-edge sets win
   always_ff @(posedge clk) begin
      if (i_rst) begin
         cmd_drop    <= 1'b0;
         err_unknown <= 1'b0;
         err_range   <= 1'b0;
      end else begin
         cmd_drop    <= (cmd_drop    & ~st_clr) | drop_set;
         err_unknown <= (err_unknown & ~st_clr) | unk_set;
         err_range   <= (err_range   & ~st_clr) | rng_set;
      end
   end

endmodule

// File: tb/tb_gpio_cmd_regfile.sv
// Directed and randomized checks of gpio_cmd_regfile against a behavioural model.
module tb_gpio_cmd_regfile;

   localparam int NB_ADDR_MEM = 15;
   localparam int N_CH        = 2;
   localparam int NB_CNT      = 64;
   localparam int NB_PHASE    = 2;
   localparam int MEM_RD_LAT  = 2;
   localparam int NW          = NB_CNT / 32;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [31:0]              gpo;
   logic [31:0]              mem_data;
   logic                     mem_full;
   logic [N_CH*NB_CNT-1:0]   ber_samp;
   logic [N_CH*NB_CNT-1:0]   ber_error;
   logic [31:0]              gpi;
   logic                     o_rst, o_enbTx, o_enbRx, o_run_log, o_read_log, o_busy;
   logic [NB_PHASE-1:0]      o_phase_sel;
   logic [NB_ADDR_MEM-1:0]   o_addr;

   logic [NB_CNT-1:0] samp_in [N_CH];
   logic [NB_CNT-1:0] err_in  [N_CH];

   // model state
   logic                   m_rst, m_tx, m_rx, m_drop, m_unk, m_rng;
   logic [NB_PHASE-1:0]    m_phase;
   logic [NB_ADDR_MEM-1:0] m_addr;
   logic [31:0]            m_gpi;
   logic [NB_CNT-1:0]      m_samp [N_CH];
   logic [NB_CNT-1:0]      m_err  [N_CH];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always_comb begin
      ber_samp  = '0;
      ber_error = '0;
      for (int c = 0; c < N_CH; c++) begin
         ber_samp[c*NB_CNT +: NB_CNT]  = samp_in[c];
         ber_error[c*NB_CNT +: NB_CNT] = err_in[c];
      end
   end

   gpio_cmd_regfile #(
      .NB_ADDR_MEM (NB_ADDR_MEM),
      .N_CH        (N_CH),
      .NB_CNT      (NB_CNT),
      .NB_PHASE    (NB_PHASE),
      .MEM_RD_LAT  (MEM_RD_LAT)
   ) dut (
      .clk                 (clk),
      .i_rst               (rst),
      .i_gpo               (gpo),
      .i_data_log_from_mem (mem_data),
      .i_mem_full          (mem_full),
      .i_ber_samp          (ber_samp),
      .i_ber_error         (ber_error),
      .o_gpi               (gpi),
      .o_rst               (o_rst),
      .o_enbTx             (o_enbTx),
      .o_enbRx             (o_enbRx),
      .o_phase_sel         (o_phase_sel),
      .o_run_log           (o_run_log),
      .o_read_log          (o_read_log),
      .o_addr_log_to_mem   (o_addr),
      .o_busy              (o_busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic er, input logic erd, input logic eb);
      check({tag, " o_rst"},   64'(o_rst),       64'(m_rst));
      check({tag, " enbTx"},   64'(o_enbTx),     64'(m_tx));
      check({tag, " enbRx"},   64'(o_enbRx),     64'(m_rx));
      check({tag, " phase"},   64'(o_phase_sel), 64'(m_phase));
      check({tag, " addr"},    64'(o_addr),      64'(m_addr));
      check({tag, " gpi"},     64'(gpi),         64'(m_gpi));
      check({tag, " run_log"}, 64'(o_run_log),   64'(er));
      check({tag, " read_log"},64'(o_read_log),  64'(erd));
      check({tag, " busy"},    64'(o_busy),      64'(eb));
   endtask

   task automatic model_reset();
      m_rst = 0; m_tx = 0; m_rx = 0; m_drop = 0; m_unk = 0; m_rng = 0;
      m_phase = '0; m_addr = '0; m_gpi = '0;
      for (int c = 0; c < N_CH; c++) begin
         m_samp[c] = '0;
         m_err[c]  = '0;
      end
   endtask

   // effect of a command accepted while idle; uses inputs present at the firing edge
   task automatic model_cmd(input logic [7:0] op, input logic [22:0] d,
                            output logic er, output logic erd);
      int ch;
      int w;
      logic [NB_CNT-1:0] v;
      er = 0; erd = 0;
      case (op)
         8'd0: m_rst = d[0];
         8'd1: m_tx  = d[0];
         8'd2: m_rx  = d[0];
         8'd3: m_phase = d[NB_PHASE-1:0];
         8'd4: er = 1;
         8'd5: begin
            if (mem_full) begin
               erd = 1;
               m_addr = d[NB_ADDR_MEM-1:0];
            end else begin
               m_gpi = 0;
            end
         end
         8'd6: begin
            for (int c = 0; c < N_CH; c++) begin
               m_samp[c] = samp_in[c];
               m_err[c]  = err_in[c];
            end
         end
         8'd7: begin
            ch = int'(d[12:5]);
            w  = int'(d[4:1]);
            if (ch >= N_CH || w >= NW) begin
               m_gpi = 0;
               m_rng = 1;
            end else begin
               v = d[0] ? m_err[ch] : m_samp[ch];
               m_gpi = 32'(v >> (32 * w));
            end
         end
         8'd8: m_gpi = {31'd0, mem_full};
         8'd9: begin
            m_gpi = {27'd0, mem_full, 1'b0, m_rng, m_unk, m_drop};
            m_rng = 0; m_unk = 0; m_drop = 0;
         end
         default: m_unk = 1;
      endcase
   endtask

   task automatic cmd(input logic [7:0] op, input logic [22:0] d);
      @(negedge clk);
      gpo = {op, 1'b1, d};
      @(negedge clk);
      gpo[23] = 1'b0;
   endtask

   // called just after a READ_MEM edge; optionally fires a command on the expiry edge
   task automatic read_wait(input string tag, input logic [31:0] fin, input bit do_drop,
                            input logic [7:0] dop, input logic [22:0] dd);
      for (int k = 1; k <= MEM_RD_LAT; k++) begin
         mem_data = (k == MEM_RD_LAT) ? fin : ~fin;
         if (do_drop && k == MEM_RD_LAT) gpo = {dop, 1'b1, dd};
         @(negedge clk);
         if (k < MEM_RD_LAT) check_all({tag, " wait"}, 1'b0, 1'b0, 1'b1);
      end
      gpo[23] = 1'b0;
      if (do_drop) m_drop = 1;
      m_gpi = fin;
      check_all({tag, " done"}, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic er, erd;
      logic [7:0]  op;
      logic [22:0] d;
      int pulses;
      int r;

      rst = 1; mem_full = 0; mem_data = 0;
      for (int c = 0; c < N_CH; c++) begin samp_in[c] = '0; err_in[c] = '0; end
      gpo = {8'd1, 1'b1, 23'd1};
      model_reset();
      repeat (3) @(negedge clk);
      check_all("reset", 1'b0, 1'b0, 1'b0);

      // strobe held through reset release fires exactly once
      rst = 0;
      @(negedge clk);
      m_tx = 1;
      check("hold_tx_latency", 64'(o_enbTx), 64'd1);
      repeat (4) @(negedge clk);
      check_all("hold_tx", 1'b0, 1'b0, 1'b0);
      gpo[23] = 1'b0;
      @(negedge clk);
      gpo = {8'd4, 1'b1, 23'd0};
      @(negedge clk);
      check("run_first", 64'(o_run_log), 64'd1);
      pulses = 1;
      repeat (4) begin
         @(negedge clk);
         if (o_run_log) pulses++;
      end
      check("run_pulses", 64'(pulses), 64'd1);
      gpo[23] = 1'b0;

      // read with a command dropped on the expiry edge
      mem_full = 1;
      cmd(8'd5, 23'h0123);
      model_cmd(8'd5, 23'h0123, er, erd);
      check_all("rd_mem", er, erd, erd);
      read_wait("rd_mem", 32'hCAFEF00D, 1'b1, 8'd3, 23'd3);
      check("rd_mem_data", 64'(gpi), 64'hCAFEF00D);
      cmd(8'd9, 23'd0);
      model_cmd(8'd9, 23'd0, er, erd);
      check_all("status1", er, erd, 1'b0);
      check("status1_drop", 64'(gpi[0]), 64'd1);
      cmd(8'd9, 23'd0);
      model_cmd(8'd9, 23'd0, er, erd);
      check("status2_drop", 64'(gpi[0]), 64'd0);

      // coherent snapshot, then live inputs change
      err_in[1] = 64'h1_0000_0002;
      samp_in[0] = 64'h1111_2222_3333_4444;
      cmd(8'd6, 23'd0);
      model_cmd(8'd6, 23'd0, er, erd);
      err_in[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      samp_in[0] = '0;
      cmd(8'd7, 23'h021);
      model_cmd(8'd7, 23'h021, er, erd);
      check("ber_e1w0", 64'(gpi), 64'h2);
      cmd(8'd7, 23'h023);
      model_cmd(8'd7, 23'h023, er, erd);
      check("ber_e1w1", 64'(gpi), 64'h1);
      cmd(8'd7, 23'h002);
      model_cmd(8'd7, 23'h002, er, erd);
      check("ber_s0w1", 64'(gpi), 64'h11112222);

      // range and unknown-opcode errors
      cmd(8'd7, 23'h0A0);
      model_cmd(8'd7, 23'h0A0, er, erd);
      check("ber_range_gpi", 64'(gpi), 64'h0);
      cmd(8'h20, 23'd0);
      model_cmd(8'h20, 23'd0, er, erd);
      check_all("unknown", er, erd, 1'b0);
      cmd(8'd9, 23'd0);
      model_cmd(8'd9, 23'd0, er, erd);
      check("status_errs", 64'(gpi), 64'h16);

      // randomized commands
      for (int i = 0; i < 300; i++) begin
         for (int c = 0; c < N_CH; c++) begin
            samp_in[c] = {$urandom, $urandom};
            err_in[c]  = {$urandom, $urandom};
         end
         mem_full = ($urandom_range(0, 3) != 0);
         r = int'($urandom_range(0, 10));
         op = (r == 10) ? 8'($urandom_range(10, 255)) : 8'(r);
         d  = 23'($urandom);
         if (op == 8'd7) begin
            d[12:5] = 8'($urandom_range(0, N_CH));
            d[4:1]  = 4'($urandom_range(0, NW));
         end
         cmd(op, d);
         model_cmd(op, d, er, erd);
         check_all("rnd", er, erd, erd);
         if (erd)
            read_wait("rnd_rd", $urandom, bit'($urandom_range(0, 1)),
                      8'($urandom), 23'($urandom));
      end

      // reset one cycle into a read aborts it and leaves gpi at zero
      mem_full = 1;
      mem_data = 32'h1234_5678;
      cmd(8'd5, 23'h55);
      rst = 1;
      @(negedge clk);
      model_reset();
      check_all("rst_abort", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 0;
      repeat (MEM_RD_LAT + 2) @(negedge clk);
      check_all("rst_after", 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
